// File: rtl/audio_mixer_dsm.sv
// N-channel time-multiplexed audio mixer with per-channel gain, saturating PCM output
// and a selectable 1st/2nd-order 1-bit delta-sigma DAC.
module audio_mixer_dsm #(
    parameter int unsigned NCH      = 8,
    parameter int unsigned IN_W     = 10,
    parameter int unsigned GAIN_W   = 4,
    parameter int unsigned OUT_W    = 16,
    parameter int unsigned GAIN_RST = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NCH*IN_W-1:0] ch_in,
    input  logic                wr,
    input  logic [3:0]          adr,
    input  logic [7:0]          din,
    output logic [OUT_W-1:0]    pcm_out,
    output logic                sample_stb,
    output logic                dac_out
);

    localparam int unsigned IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned PROD_W = IN_W + GAIN_W;
    localparam int unsigned ACC_W  = PROD_W + $clog2(NCH + 1);
    localparam int unsigned SUM_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
    localparam int unsigned INT_W  = OUT_W + 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
    localparam logic [4:0]       NCH_L    = 5'(NCH);

    // Control registers
    logic [GAIN_W-1:0] gain [NCH];
    logic              mute;
    logic              order;

    // Sequencer state
    logic [IDX_W-1:0]  ch_idx;
    logic [ACC_W-1:0]  acc;

    // Modulator state
    logic [OUT_W-1:0]        fbk;
    logic signed [INT_W-1:0] i1;
    logic signed [INT_W-1:0] i2;

    logic [IN_W-1:0]   ch_arr [NCH];
    logic [IN_W-1:0]   ch_sel;
    logic [GAIN_W-1:0] gain_sel;
    logic [PROD_W-1:0] prod;
    logic [SUM_W-1:0]  frame_sum;
    logic [OUT_W-1:0]  frame_sat;
    logic              frame_end;

    logic gain_wr;
    logic ctrl_wr;
    logic order_chg;
    logic unused_din;

    logic [OUT_W-1:0]        dsm_x;
    logic [OUT_W:0]          fo_sum;
    logic signed [INT_W-1:0] q;
    logic signed [INT_W-1:0] i1_nxt;
    logic signed [INT_W-1:0] i2_nxt;

    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign ch_arr[k] = ch_in[k*IN_W +: IN_W];
    end

    assign unused_din = ^din;

    always_comb begin
        ch_sel    = ch_arr[ch_idx];
        gain_sel  = gain[ch_idx];
        prod      = PROD_W'(ch_sel) * PROD_W'(gain_sel);
        frame_sum = SUM_W'(acc) + SUM_W'(prod);
        frame_sat = (|frame_sum[SUM_W-1:OUT_W]) ? '1 : frame_sum[OUT_W-1:0];
        frame_end = (ch_idx == LAST_IDX);
    end

    always_comb begin
        gain_wr   = wr && ({1'b0, adr} < NCH_L);
        ctrl_wr   = wr && (adr == 4'hF);
        order_chg = ctrl_wr && (din[1] != order);
    end

    // Mute gates the modulator input directly so silence is immediate, not next frame.
    always_comb begin
        dsm_x  = mute ? '0 : pcm_out;
        fo_sum = {1'b0, dsm_x} + {1'b0, fbk};
        q      = dac_out ? $signed({4'b0000, {OUT_W{1'b1}}}) : '0;
        i1_nxt = i1 + $signed({4'b0000, dsm_x}) - q;
        // Second integrator takes the freshly updated first integrator: NTF = (1 - z^-1)^2.
        i2_nxt = i2 + i1_nxt - q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                gain[k] <= GAIN_W'(GAIN_RST);
            end
            mute  <= 1'b0;
            order <= 1'b0;
        end else begin
            if (gain_wr) begin
                gain[adr[IDX_W-1:0]] <= din[GAIN_W-1:0];
            end
            if (ctrl_wr) begin
                mute  <= din[0];
                order <= din[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ch_idx     <= '0;
            acc        <= '0;
            pcm_out    <= '0;
            sample_stb <= 1'b0;
        end else begin
            sample_stb <= frame_end;
            if (frame_end) begin
                ch_idx  <= '0;
                acc     <= '0;
                pcm_out <= mute ? '0 : frame_sat;
            end else begin
                ch_idx <= ch_idx + 1'b1;
                acc    <= ACC_W'(frame_sum);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fbk     <= '0;
            i1      <= '0;
            i2      <= '0;
            dac_out <= 1'b0;
        end else if (order_chg) begin
            fbk     <= '0;
            i1      <= '0;
            i2      <= '0;
            dac_out <= 1'b0;
        end else if (order) begin
            i1      <= i1_nxt;
            i2      <= i2_nxt;
            dac_out <= ~i2_nxt[INT_W-1];
        end else begin
            fbk     <= fo_sum[OUT_W-1:0];
            dac_out <= fo_sum[OUT_W];
        end
    end

endmodule

// File: tb/tb_audio_mixer_dsm.sv
// Self-checking bench for audio_mixer_dsm: table vectors, hand-written corner sequences,
// and randomized traffic tracked cycle by cycle against a behavioural model.
module tb_audio_mixer_dsm;

    localparam int NCH      = 8;
    localparam int IN_W     = 10;
    localparam int GAIN_W   = 4;
    localparam int OUT_W    = 16;
    localparam int GAIN_RST = 8;
    localparam int BUS_W    = NCH * IN_W;
    localparam int INT_W    = OUT_W + 4;
    localparam longint MAXV = (longint'(1) << OUT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [BUS_W-1:0] ch_bus;
    logic             wr;
    logic [3:0]       adr;
    logic [7:0]       din;
    logic [OUT_W-1:0] pcm_out;
    logic             sample_stb;
    logic             dac_out;
    logic [OUT_W-1:0] pcm1;
    logic             stb1;
    logic             dac1;

    always #5 clk = ~clk;

    audio_mixer_dsm #(
        .NCH(NCH), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W), .GAIN_RST(GAIN_RST)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ch_in(ch_bus), .wr(wr), .adr(adr), .din(din),
        .pcm_out(pcm_out), .sample_stb(sample_stb), .dac_out(dac_out)
    );

    // Single-channel instance: every cycle ends a frame.
    audio_mixer_dsm #(
        .NCH(1), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W), .GAIN_RST(GAIN_RST)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .ch_in(ch_bus[IN_W-1:0]), .wr(wr), .adr(adr),
        .din(din), .pcm_out(pcm1), .sample_stb(stb1), .dac_out(dac1)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int     m_gain [NCH];
    int     m_cyc;
    longint m_sum;
    longint m_pcm;
    bit     m_stb;
    bit     m_dac;
    longint m_fbk;
    longint m_i1;
    longint m_i2;
    bit     m_mute;
    bit     m_order;

    typedef struct {
        logic [BUS_W-1:0] ch;
        int               gain;
        bit               mute;
        int               exp;
        int               exp1;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint wrap_int(input longint v);
        longint m;
        m = longint'(1) << INT_W;
        v = v & (m - 1);
        if (v >= m / 2) v = v - m;
        return v;
    endfunction

    function automatic logic [BUS_W-1:0] mk_bus(input int c0, input int c1, input int c2,
                                                 input int c3, input int c4, input int rest);
        logic [BUS_W-1:0] b;
        for (int k = 0; k < NCH; k++) b[k*IN_W +: IN_W] = IN_W'(rest);
        b[0*IN_W +: IN_W] = IN_W'(c0);
        b[1*IN_W +: IN_W] = IN_W'(c1);
        b[2*IN_W +: IN_W] = IN_W'(c2);
        b[3*IN_W +: IN_W] = IN_W'(c3);
        b[4*IN_W +: IN_W] = IN_W'(c4);
        return b;
    endfunction

    // One clock edge of the mixer as described: frame mixing, modulation, register writes.
    task automatic model_step();
        int     slot;
        longint contrib, x, s, q, total, nfbk, ni1, ni2;
        bit     ndac;
        if (!reset_n) begin
            for (int k = 0; k < NCH; k++) m_gain[k] = GAIN_RST;
            m_cyc = 0; m_sum = 0; m_pcm = 0; m_stb = 0; m_dac = 0;
            m_fbk = 0; m_i1 = 0; m_i2 = 0; m_mute = 0; m_order = 0;
            return;
        end
        slot    = m_cyc % NCH;
        contrib = longint'(ch_bus[slot*IN_W +: IN_W]) * m_gain[slot];
        x       = m_mute ? 0 : m_pcm;
        nfbk = m_fbk; ni1 = m_i1; ni2 = m_i2;
        if (!m_order) begin
            s    = x + m_fbk;
            ndac = (s > MAXV);
            nfbk = s & MAXV;
        end else begin
            q    = m_dac ? MAXV : 0;
            ni1  = wrap_int(m_i1 + x - q);
            ni2  = wrap_int(m_i2 + ni1 - q);
            ndac = (ni2 >= 0);
        end
        if (slot == NCH - 1) begin
            total = m_sum + contrib;
            m_pcm = m_mute ? 0 : ((total > MAXV) ? MAXV : total);
            m_stb = 1;
            m_sum = 0;
        end else begin
            m_sum = m_sum + contrib;
            m_stb = 0;
        end
        if (wr) begin
            if (int'(adr) < NCH) begin
                m_gain[adr] = int'(din) % (1 << GAIN_W);
            end else if (adr == 4'hF) begin
                if (din[1] != m_order) begin
                    ndac = 0; nfbk = 0; ni1 = 0; ni2 = 0;
                end
                m_mute  = din[0];
                m_order = din[1];
            end
        end
        m_dac = ndac; m_fbk = nfbk; m_i1 = ni1; m_i2 = ni2;
        m_cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        chk("track pcm_out", pcm_out, m_pcm);
        chk("track sample_stb", sample_stb, m_stb);
        chk("track dac_out", dac_out, m_dac);
    endtask

    task automatic wr_reg(input int a, input int d);
        wr  = 1'b1;
        adr = 4'(a);
        din = 8'(d);
        tick();
        wr  = 1'b0;
    endtask

    // Advance until the next edge processes channel slot s.
    task automatic to_slot(input int s);
        while (m_cyc % NCH != s) tick();
    endtask

    task automatic apply_vec(input int i);
        for (int k = 0; k < NCH; k++) wr_reg(k, vecs[i].gain);
        wr_reg(15, vecs[i].mute ? 1 : 0);
        ch_bus = vecs[i].ch;
        repeat (2 * NCH) tick();
        to_slot(NCH - 1);
        tick();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones, nonalt, cnt, prev;
        bit seen [25];

        vecs[0] = '{mk_bus(1023, 0, 0, 0, 0, 0), 8, 0, 8184, 8184};
        vecs[1] = '{mk_bus(1023, 1023, 1023, 1023, 1023, 1023), 15, 0, 65535, 15345};
        vecs[2] = '{mk_bus(1023, 1023, 1023, 1023, 1023, 1023), 1, 0, 8184, 1023};
        vecs[3] = '{mk_bus(1023, 1023, 1023, 1023, 4, 0), 8, 0, 32768, 8184};
        vecs[4] = '{mk_bus(1023, 1023, 2, 0, 0, 0), 8, 0, 16384, 8184};
        vecs[5] = '{mk_bus(0, 0, 0, 0, 0, 0), 8, 0, 0, 0};
        vecs[6] = '{mk_bus(1023, 1023, 1023, 1023, 1023, 1023), 8, 1, 0, 0};
        vecs[7] = '{mk_bus(100, 100, 100, 100, 100, 100), 3, 0, 2400, 300};
        vecs[8] = '{mk_bus(1023, 1023, 1023, 1023, 1023, 1023), 0, 0, 0, 0};

        reset_n = 1'b0;
        ch_bus  = '0;
        wr      = 1'b0;
        adr     = '0;
        din     = '0;

        // Reset and first frames
        repeat (3) tick();
        chk("reset pcm_out", pcm_out, 0);
        chk("reset sample_stb", sample_stb, 0);
        chk("reset dac_out", dac_out, 0);
        reset_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            seen[k] = sample_stb;
            if (k <= 3) chk("nch1 sample_stb held", stb1, 1);
        end
        cnt = 0;
        for (int k = 1; k <= 24; k++) cnt += int'(seen[k]);
        chk("strobe at cycle 8", seen[8], 1);
        chk("strobe at cycle 16", seen[16], 1);
        chk("strobe at cycle 24", seen[24], 1);
        chk("strobe count in 24 cycles", cnt, 3);

        // Table vectors
        for (int i = 0; i < 9; i++) begin
            apply_vec(i);
            chk($sformatf("vec%0d pcm_out", i), pcm_out, vecs[i].exp);
            chk($sformatf("vec%0d sample_stb", i), sample_stb, 1);
            chk($sformatf("vec%0d nch1 pcm_out", i), pcm1, vecs[i].exp1);
        end

        // Gain 0 silences the channel from the next complete frame
        apply_vec(0);
        wr_reg(0, 0);
        to_slot(0);
        to_slot(NCH - 1);
        tick();
        chk("gain0 pcm_out", pcm_out, 0);

        // Mute: modulator silent immediately, PCM zero at next strobe, mix returns on unmute
        apply_vec(0);
        wr_reg(15, 1);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("mute dac_out", dac_out, 0);
        end
        to_slot(NCH - 1);
        tick();
        chk("mute pcm_out", pcm_out, 0);
        wr_reg(15, 0);
        to_slot(0);
        to_slot(NCH - 1);
        tick();
        chk("unmute pcm_out", pcm_out, 8184);

        // Gain write coinciding with frame end uses the old gain for the last slot
        for (int k = 0; k < NCH; k++) wr_reg(k, 8);
        ch_bus = '0;
        ch_bus[(NCH-1)*IN_W +: IN_W] = IN_W'(1000);
        repeat (2 * NCH) tick();
        to_slot(NCH - 1);
        wr_reg(NCH - 1, 1);
        chk("frame-end write old gain", pcm_out, 8000);
        to_slot(NCH - 1);
        tick();
        chk("frame-end write new gain", pcm_out, 1000);

        // First-order modulation at half scale
        apply_vec(3);
        ones = 0; nonalt = 0; prev = int'(dac_out);
        for (int k = 0; k < 4096; k++) begin
            tick();
            ones += int'(dac_out);
            if (int'(dac_out) == prev) nonalt++;
            prev = int'(dac_out);
        end
        chk("first-order ones in 4096", ones, 2048);
        chk("first-order non-alternating", nonalt, 0);

        // Second-order modulation at quarter scale
        apply_vec(4);
        wr_reg(15, 2);
        ones = 0;
        for (int k = 0; k < 4096; k++) begin
            tick();
            ones += int'(dac_out);
        end
        chk("second-order ones within 1024+-2", (ones >= 1022 && ones <= 1026) ? 1 : 0, 1);

        // Mid-frame reset at slot 4
        to_slot(4);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            cnt++;
            if (sample_stb) break;
        end
        chk("first strobe after mid-frame reset", cnt, 8);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < NCH; k++) ch_bus[k*IN_W +: IN_W] = IN_W'($urandom_range(0, 1023));
            if ($urandom_range(0, 5) == 0) begin
                wr  = 1'b1;
                adr = 4'($urandom_range(0, 15));
                din = 8'($urandom);
            end
            tick();
            wr = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_mixer_dsm.md
Name: audio_mixer_dsm

Overview:
- Parametrised N-channel audio mixer with a 1-bit delta-sigma DAC; the next generation of the fixed PSG/8253/beep summing DAC at the top level.
- Adds per-channel gain registers on the CPU I/O bus, time-multiplexed accumulation, a saturating PCM output with a sample strobe, master mute, and selectable 1st/2nd-order modulation.
- Sits between the sound sources (PSG, 8253, beep/CMT) and dac_out.

Parameters:
- NCH, 8, number of input channels (1..15).
- IN_W, 10, unsigned width of each channel sample.
- GAIN_W, 4, per-channel gain register width; gain 0 = mute channel.
- OUT_W, 16, unsigned PCM output width.
- GAIN_RST, 8, reset value of every gain register.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ch_in  in  NCH*IN_W  channel samples; channel k in bits [k*IN_W +: IN_W]; sampled at its own slot.
- wr  in  1  register write strobe, one cycle per write.
- adr  in  4  register address.
- din  in  8  register write data.
- pcm_out  out  OUT_W  saturated mix, updated once per frame.
- sample_stb  out  1  one-cycle pulse in the cycle pcm_out updates.
- dac_out  out  1  delta-sigma bitstream.

Behaviour:
- **Reset** (reset_n=0 at clk edge):
  - gain[k]=GAIN_RST; ch_idx=0; acc=0.
  - pcm_out=0; sample_stb=0; dac_out=0.
  - All DSM state = 0; mute=0; order=0.
- **Registers:**
  - wr with adr<NCH: gain[adr] <= din[GAIN_W-1:0].
  - wr with adr=4'hF: mute <= din[0]; order <= din[1].
  - Writes to any other adr are ignored.
  - A new gain takes effect from the next clk. A channel already summed this frame keeps its old contribution.
- **Sequencer:**
  - ch_idx counts 0..NCH-1 and wraps, one channel per clk. Frame = NCH cycles.
  - prod = ch_in[ch_idx] * gain[ch_idx], unsigned, IN_W+GAIN_W bits.
  - acc width = IN_W+GAIN_W+clog2(NCH+1).
  - For ch_idx<NCH-1: acc <= acc + prod.
  - At ch_idx=NCH-1:
    - pcm_out <= mute ? 0 : sat(acc+prod). sat clamps to 2^OUT_W-1 when the sum is ≥2^OUT_W.
    - sample_stb <= 1 for that one cycle.
    - acc <= 0.
  - Latency: channel 0 input to pcm_out is NCH cycles.
- **DSM**, clocked every clk. Input x = mute ? 0 : pcm_out, so mute takes effect immediately and not only at the next frame.
  - order=0 (first order):
    - sum = x + fbk, OUT_W+1 bits.
    - dac_out <= sum[OUT_W]; fbk <= sum[OUT_W-1:0].
  - order=1 (second order):
    - Signed integrators i1, i2 of width OUT_W+4.
    - q = dac_out ? 2^OUT_W-1 : 0.
    - i1 <= i1 + x - q.
    - i2 <= i2 + i1 - q.
    - dac_out <= (i2 ≥ 0) evaluated on the updated i2, registered.
- **Order change:** a write that changes order clears fbk, i1, i2 and dac_out on the same edge.
- **Boundaries:**
  - NCH=1: every cycle is a frame end, so sample_stb is held high.
  - All gains 0: pcm_out=0 and dac_out stays 0 in first-order mode.
  - x=2^OUT_W-1 first order: dac_out is 1 on all but one cycle per 2^OUT_W.
  - Mid-frame reset: the partial acc is discarded; the first sample_stb comes NCH cycles after reset release.
  - A simultaneous wr and frame end uses the pre-write gain for the last slot.

Test Plan:
1. **Reset and first frame.** Hold reset_n=0 for 3 cycles, then release with ch_in all 0.
   - All outputs are 0.
   - sample_stb pulses on cycles 8, 16, 24 after release.
2. **Single channel.** ch0=1023, all others 0, gains at reset (8).
   - pcm_out = 8184 at the first strobe.
   - Write gain[0]=0 → pcm_out = 0 at the next complete frame.
3. **Saturation.** All ch=1023, all gains=15 (sum 122760).
   - pcm_out = 65535.
   - Gains=1 → pcm_out = 8184.
4. **Mute.** With pcm_out = 8184, write adr F din=01.
   - dac_out stays 0 from the next cycle.
   - The next strobe gives pcm_out = 0.
   - Write din=00 → the mix returns.
5. **First-order DSM.** Drive so pcm_out = 0x8000.
   - dac_out alternates 0,1.
   - Exactly 2048 ones in 4096 cycles.
6. **Second-order DSM.**
   - Write order=1 with pcm_out = 0x4000; dac_out has 1024±2 ones in 4096 cycles.
   - Reset mid-frame at ch_idx=4: the next strobe is 8 cycles after release.
